accumulator_alu: RTL

ACCUMULATOR_ALU -- requirements
Module: accumulator_alu

---
 rtl/sap1_pkg.sv | 5 +
 rtl/accumulator_alu_add_sub.sv | 11 +
 rtl/accumulator_alu.sv | 59 +++++
 3 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: shared datapath width and accumulator reset value for the SAP-1 slice
package sap1_pkg;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] RESET_ACC = 8'h00;
endpackage

// File: rtl/accumulator_alu_add_sub.sv
// add_sub: 9-bit two's-complement adder/subtracter, sum[8] is carry (no-borrow on subtract)
module add_sub
  import sap1_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              su,
  output logic [DATA_W:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, su ? ~b : b} + {{DATA_W{1'b0}}, su};
endmodule

// File: rtl/accumulator_alu.sv
// accumulator_alu: SAP-1 accumulator with add/sub unit and bus drive; SAP1_FLAGS_EN adds carry/zero flags
module accumulator_alu
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              nLa,
  input  logic              Ea,
  input  logic              Su,
  input  logic              Eu,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              bus_err
`ifdef SAP1_FLAGS_EN
  ,
  output logic              carry_flag,
  output logic              zero_flag
`endif
);
  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;
  logic              err;
  add_sub u_add_sub (.a(acc), .b(b_in), .su(Su), .sum(sum));
  // accumulator loads from the bus; a simultaneous Ea/Eu drive latches a sticky error
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= RESET_ACC;
      err <= 1'b0;
    end else begin
      if (!nLa) acc <= bus_in;
      if (Ea && Eu) err <= 1'b1;
    end
  end
  // bus mux: accumulator wins over the adder when both are enabled
  always_comb begin
    bus_oe  = Ea | Eu;
    bus_out = Ea ? acc : Eu ? sum[DATA_W-1:0] : '0;
  end
  assign acc_out = acc;
  assign bus_err = err;
`ifdef SAP1_FLAGS_EN
  // flags capture the adder result only when it actually drives the bus
  always_ff @(posedge clk) begin
    if (clr) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b1;
    end else if (Eu && !Ea) begin
      carry_flag <= sum[DATA_W];
      zero_flag  <= sum[DATA_W-1:0] == '0;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum[DATA_W];
`endif
endmodule
